// File: rtl/spi_cmd_sequencer.sv
`default_nettype none
// == spi_cmd_sequencer : request FIFO, one-at-a-time issue to spi_master, watchdog, in-order responses ==
// == rev 1.0 ==
module spi_cmd_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_port_no,
  input  logic [4:0]  req_dev_addr,
  input  logic [15:0] req_reg_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_rw,
  output logic        rsp_err,
  output logic        spi_start,
  input  logic        spi_busy,
  output logic        spi_rw,
  output logic [1:0]  spi_port_no,
  output logic [4:0]  spi_dev_addr,
  output logic [15:0] spi_reg_addr,
  output logic [31:0] spi_data_in,
  input  logic [31:0] spi_data_out,
  input  logic        spi_out_valid,
  output logic        idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic        rw;
    logic [1:0]  port_no;
    logic [4:0]  dev_addr;
    logic [15:0] reg_addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [TW-1:0] timer;
  logic [31:0]   cap_data;
  logic          push;
  logic          pop;
  logic          timeout;
  logic [31:0]   data_now;

  assign req_ready = (count != FULL_COUNT);
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && (count != '0) && !spi_busy && !rsp_valid;
  assign timeout   = (timer == TIMER_LAST);
  // A strobe coinciding with the busy fall must still reach the response.
  assign data_now  = spi_out_valid ? spi_data_out : cap_data;
  assign idle      = (count == '0) && (state == S_IDLE) && !rsp_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {req_rw, req_port_no, req_dev_addr, req_reg_addr, req_wdata};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      cap_data     <= '0;
      spi_start    <= 1'b0;
      spi_rw       <= 1'b0;
      spi_port_no  <= '0;
      spi_dev_addr <= '0;
      spi_reg_addr <= '0;
      spi_data_in  <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_rw       <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            spi_rw       <= mem[rd_ptr].rw;
            spi_port_no  <= mem[rd_ptr].port_no;
            spi_dev_addr <= mem[rd_ptr].dev_addr;
            spi_reg_addr <= mem[rd_ptr].reg_addr;
            spi_data_in  <= mem[rd_ptr].wdata;
            spi_start    <= 1'b1;
            timer        <= '0;
            cap_data     <= '0;
            state        <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (timeout) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rw    <= spi_rw;
            rsp_rdata <= '0;
            state     <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
            if (spi_busy) state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (spi_out_valid) cap_data <= spi_data_out;
          if (timeout) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rw    <= spi_rw;
            rsp_rdata <= '0;
            state     <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
            if (!spi_busy) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rw    <= spi_rw;
              rsp_rdata <= spi_rw ? data_now : '0;
              state     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
